// File: rtl/key_led_pio_pkg.sv
// Shared register map for the key/LED parallel I/O block.
package key_led_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] REG_KEYS     = 3'd0;
    localparam logic [ADDR_W-1:0] REG_LED      = 3'd1;
    localparam logic [ADDR_W-1:0] REG_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] REG_EDGE     = 3'd3;
    localparam logic [ADDR_W-1:0] REG_LED_SET  = 3'd4;
    localparam logic [ADDR_W-1:0] REG_LED_CLR  = 3'd5;

endpackage

// File: rtl/key_led_pio_debounce.sv
// Two-flop synchroniser plus debounce for one raw active-low key.
// key_state keeps the raw polarity (1 = released).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Down-counter: 0 means idle; the first differing cycle loads N-1 and the
    // N-th consecutive differing cycle hits the terminal count of 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            key_state <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], key_raw};
            if (sync_q[1] == key_state) begin
                cnt_q <= '0;
            end else if (cnt_q == '0) begin
                cnt_q <= CNT_LOAD;
            end else if (cnt_q == CNT_ONE) begin
                key_state <= sync_q[1];
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/key_led_pio.sv
// Debounced key inputs with press-edge interrupts and an LED register,
// exposed through a small Avalon-MM slave.
module key_led_pio
    import key_led_pio_pkg::*;
#(
    parameter int KEY_WIDTH       = 4,
    parameter int LED_WIDTH       = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [KEY_WIDTH-1:0] keys_export,
    output logic [LED_WIDTH-1:0] leds_export,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq
);

    logic [KEY_WIDTH-1:0] key_state;
    logic [KEY_WIDTH-1:0] pressed;
    logic [KEY_WIDTH-1:0] pressed_prev;
    logic [KEY_WIDTH-1:0] mask_q, mask_next;
    logic [KEY_WIDTH-1:0] edge_q, edge_next;
    logic [KEY_WIDTH-1:0] w1c;
    logic [KEY_WIDTH-1:0] wd_key;
    logic [LED_WIDTH-1:0] led_q, led_next;
    logic [LED_WIDTH-1:0] wd_led;
    logic [31:0]          rd_data;

    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk_clk),
            .rst      (reset_reset),
            .key_raw  (keys_export[i]),
            .key_state(key_state[i])
        );
    end

    assign pressed     = ~key_state;
    assign wd_key      = avs_writedata[KEY_WIDTH-1:0];
    assign wd_led      = avs_writedata[LED_WIDTH-1:0];
    assign leds_export = led_q;

    always_comb begin
        led_next  = led_q;
        mask_next = mask_q;
        w1c       = '0;
        if (avs_write) begin
            case (avs_address)
                REG_LED:      led_next  = wd_led;
                REG_IRQ_MASK: mask_next = wd_key;
                REG_EDGE:     w1c       = wd_key;
                REG_LED_SET:  led_next  = led_q | wd_led;
                REG_LED_CLR:  led_next  = led_q & ~wd_led;
                default:      ;
            endcase
        end
        // A fresh press edge wins over a simultaneous clear of the same bit.
        edge_next = (edge_q & ~w1c) | (pressed & ~pressed_prev);
    end

    always_comb begin
        rd_data = '0;
        case (avs_address)
            REG_KEYS:     rd_data = 32'(pressed);
            REG_LED:      rd_data = 32'(led_q);
            REG_IRQ_MASK: rd_data = 32'(mask_q);
            REG_EDGE:     rd_data = 32'(edge_q);
            default:      rd_data = '0;
        endcase
    end

    // irq is built from next-state values so it moves on the same edge as EDGE/IRQ_MASK.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            led_q        <= '0;
            mask_q       <= '0;
            edge_q       <= '0;
            pressed_prev <= '0;
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            led_q        <= led_next;
            mask_q       <= mask_next;
            edge_q       <= edge_next;
            pressed_prev <= pressed;
            avs_readdata <= avs_read ? rd_data : '0;
            irq          <= |(edge_next & mask_next);
        end
    end

endmodule

// File: tb/tb_key_led_pio.sv
// Self-checking bench for key_led_pio with a short debounce window.
module tb_key_led_pio;
    import key_led_pio_pkg::*;

    localparam int KW = 4;
    localparam int LW = 10;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [KW-1:0] keys = '1;
    logic [LW-1:0] leds;
    logic [2:0]    addr = '0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    key_led_pio #(
        .KEY_WIDTH      (KW),
        .LED_WIDTH      (LW),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .keys_export  (keys),
        .leds_export  (leds),
        .avs_address  (addr),
        .avs_read     (rd),
        .avs_write    (wr),
        .avs_writedata(wdata),
        .avs_readdata (rdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // Issues one read and scores it against the oldest pending expectation.
    task automatic issue_read(input logic [2:0] a);
        logic [31:0] want;
        addr = a;
        rd   = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL read_a%0d: got %h with no pending expectation", a, rdata);
        end else begin
            want = exp_q.pop_front();
            if (rdata !== want) begin
                errors++;
                $display("FAIL read_a%0d: got %h, required %h", a, rdata, want);
            end
        end
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        issue_read(a);
    endtask

    task automatic test_reset;
        wait_cycles(3);
        checks++;
        if (leds !== '0) begin errors++; $display("FAIL reset_leds: got %h, required 0", leds); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", irq); end
        checks++;
        if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
        rst = 1'b0;
        wait_cycles(2);
        bus_read(REG_KEYS, 32'h0);
        bus_read(REG_LED, 32'h0);
        bus_read(REG_IRQ_MASK, 32'h0);
        bus_read(REG_EDGE, 32'h0);
    endtask

    task automatic test_glitch;
        keys[0] = 1'b0;
        wait_cycles(DC - 1);
        keys[0] = 1'b1;
        wait_cycles(8);
        bus_read(REG_KEYS, 32'h0);
        bus_read(REG_EDGE, 32'h0);
    endtask

    task automatic test_press_irq;
        bus_write(REG_IRQ_MASK, 32'h4);
        keys[2] = 1'b0;
        wait_cycles(10);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL press_irq: got %b, required 1", irq); end
        bus_read(REG_KEYS, 32'h4);
        bus_read(REG_EDGE, 32'h4);
        bus_write(REG_EDGE, 32'h4);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b, required 0", irq); end
        bus_read(REG_EDGE, 32'h0);
        keys[2] = 1'b1;
        wait_cycles(10);
        bus_read(REG_KEYS, 32'h0);
        bus_read(REG_EDGE, 32'h0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL release_irq: got %b, required 0", irq); end
    endtask

    task automatic test_led;
        bus_write(REG_LED, 32'h3FF);
        checks++;
        if (leds !== 10'h3FF) begin errors++; $display("FAIL led_write: got %h, required 3ff", leds); end
        bus_write(REG_LED_CLR, 32'h00F);
        checks++;
        if (leds !== 10'h3F0) begin errors++; $display("FAIL led_clr: got %h, required 3f0", leds); end
        bus_write(REG_LED_SET, 32'h400);
        checks++;
        if (leds !== 10'h3F0) begin errors++; $display("FAIL led_set_wide: got %h, required 3f0", leds); end
        bus_read(REG_LED, 32'h3F0);
        bus_write(REG_LED_SET, 32'h005);
        bus_read(REG_LED, 32'h3F5);
        bus_write(REG_LED_CLR, 32'h005);
        bus_read(REG_LED, 32'h3F0);
    endtask

    task automatic test_w1c_collision;
        keys[1] = 1'b0;
        wait_cycles(10);
        bus_read(REG_EDGE, 32'h2);
        keys[1] = 1'b1;
        wait_cycles(10);
        bus_read(REG_KEYS, 32'h0);
        keys[1] = 1'b0;
        // 2 synchroniser + DC debounce cycles: the edge lands on the next clock
        wait_cycles(DC + 2);
        bus_write(REG_EDGE, 32'h2);
        bus_read(REG_EDGE, 32'h2);
        bus_write(REG_EDGE, 32'h2);
        bus_read(REG_EDGE, 32'h0);
        keys[1] = 1'b1;
        wait_cycles(10);
        bus_read(REG_EDGE, 32'h0);
    endtask

    task automatic test_reserved;
        bus_read(3'd4, 32'h0);
        bus_read(3'd6, 32'h0);
        bus_read(3'd7, 32'h0);
        bus_write(REG_KEYS, 32'hFFFF_FFFF);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(REG_LED, 32'h3F0);
        bus_read(REG_IRQ_MASK, 32'h4);
        bus_read(REG_EDGE, 32'h0);
        bus_read(REG_KEYS, 32'h0);
        checks++;
        if (leds !== 10'h3F0) begin errors++; $display("FAIL reserved_leds: got %h, required 3f0", leds); end
        bus_write(REG_IRQ_MASK, 32'hFFFF_FFF3);
        bus_read(REG_IRQ_MASK, 32'h3);
    endtask

    task automatic test_read_write_collision;
        logic [31:0] want;
        exp_q.push_back(32'h3F0);
        addr  = REG_LED;
        wdata = 32'h055;
        rd    = 1'b1;
        wr    = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        want = exp_q.pop_front();
        checks++;
        if (rdata !== want) begin errors++; $display("FAIL rw_rdata: got %h, required %h", rdata, want); end
        checks++;
        if (leds !== 10'h055) begin errors++; $display("FAIL rw_leds: got %h, required 055", leds); end
        bus_read(REG_LED, 32'h055);
    endtask

    task automatic test_reset_mid_debounce;
        keys[0] = 1'b0;
        wait_cycles(10);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b, required 1", irq); end
        keys[0] = 1'b1;
        keys[3] = 1'b0;
        wait_cycles(3);
        rst = 1'b1;
        #1;
        checks++;
        if (leds !== '0) begin errors++; $display("FAIL midrst_leds: got %h, required 0", leds); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b, required 0", irq); end
        checks++;
        if (rdata !== '0) begin errors++; $display("FAIL midrst_rdata: got %h, required 0", rdata); end
        wait_cycles(2);
        rst = 1'b0;
        // Edge is set on the (DC+3)-th clock after release; a read sees it one clock later.
        for (int k = 1; k <= DC + 4; k++) begin
            exp_q.push_back((k == DC + 4) ? 32'h8 : 32'h0);
        end
        for (int k = 1; k <= DC + 4; k++) begin
            issue_read(REG_EDGE);
        end
        bus_read(REG_KEYS, 32'h8);
        bus_read(REG_IRQ_MASK, 32'h0);
        bus_read(REG_LED, 32'h0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL postrst_irq: got %b, required 0", irq); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press_irq();
        test_led();
        test_w1c_collision();
        test_reserved();
        test_read_write_collision();
        test_reset_mid_debounce();
        wait_cycles(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
